// File: rtl/chi_stage.sv
// -----------------------------------------------------------------------------
// chi_stage
//
// Row-wise nonlinear mixing stage of the permutation round. Walks the 64
// slices of the 5x5x64 state (64 lines of 25 bits), applies the chi
// substitution inside every 5-bit row of each line, and writes the result
// back to the same address. A one-cycle `done` pulse hands the state memory
// on to the add-round-constant stage.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset
//   chi_en        in   1  start request, sampled only in IDLE
//   line_in       in  25  state line at address cnt_value (combinational read)
//   cnt_value     out  6  read address / slice index
//   write_enable  out  1  state memory write strobe
//   write_addr    out  6  state memory write address
//   write_value   out 25  chi result to store
//   done          out  1  one-cycle pulse at the end of a pass
//
// Build option
//   CHI_OUT_REG_EN  when defined, the write port (enable/address/value) is
//                   driven from a register stage, which breaks the
//                   memory-read -> chi -> memory-write path. This adds a
//                   FLUSH state and one cycle of latency.
// -----------------------------------------------------------------------------
module chi_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        chi_en,
    input  logic [24:0] line_in,
    output logic [5:0]  cnt_value,
    output logic        write_enable,
    output logic [5:0]  write_addr,
    output logic [24:0] write_value,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
`ifdef CHI_OUT_REG_EN
        ,
        S_FLUSH = 2'd3
`endif
    } state_t;

    localparam logic [5:0] LAST_SLICE = 6'd63;

    // -------------------------------------------------------------------------
    // Chi on one 25-bit line. Bit 5*y+x is column x of row y; the neighbour
    // indices wrap inside the row, so rows never interact.
    // -------------------------------------------------------------------------
    function automatic logic [24:0] chi_line(input logic [24:0] a);
        logic [24:0] b;
        b = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                b[5*y + x] = a[5*y + x]
                           ^ (~a[5*y + ((x + 1) % 5)] & a[5*y + ((x + 2) % 5)]);
            end
        end
        return b;
    endfunction

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_done;

    logic        w_run;
    logic        w_last;
    logic [24:0] w_chi;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == LAST_SLICE);
    assign w_chi  = chi_line(line_in);

    // -------------------------------------------------------------------------
    // Control FSM: slice counter and registered done pulse.
    // The counter is 6 bits wide, so the increment after slice 63 wraps it
    // back to 0 on its own, leaving IDLE with address 0 on the read port.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (chi_en) begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
`ifdef CHI_OUT_REG_EN
                        // Last registered write is still in flight.
                        r_state <= S_FLUSH;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`endif
                    end
                end

`ifdef CHI_OUT_REG_EN
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`endif

                S_DONE: begin
                    // chi_en is deliberately not looked at here, so a held
                    // request restarts only after one IDLE cycle.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt_value = r_cnt;
    assign done      = r_done;

    // -------------------------------------------------------------------------
    // Write port
    // -------------------------------------------------------------------------
`ifdef CHI_OUT_REG_EN
    logic        r_we;
    logic [5:0]  r_waddr;
    logic [24:0] r_wval;

    // NOTE: the data registers are reset too, because write_addr and
    // write_value have defined post-reset values; clearing r_we on reset also
    // drops a write captured from the aborted pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= 6'd0;
            r_wval  <= 25'd0;
        end else begin
            r_we    <= w_run;
            r_waddr <= r_cnt;
            r_wval  <= w_run ? w_chi : 25'd0;
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_value  = r_wval;
`else
    // Combinational write: the slice read this cycle is written this cycle.
    // Value is forced to 0 outside RUN so the port is quiet while idle.
    assign write_enable = w_run;
    assign write_addr   = r_cnt;
    assign write_value  = w_run ? w_chi : 25'd0;
`endif

endmodule

// File: doc/chi_stage.md
# chi_stage

Row-wise nonlinear mixing stage of the permutation round, sitting directly upstream of the add-round-constant stage. It walks the 64 slices of the 5x5x64 state, held as 64 lines of 25 bits. For each slice it reads the line, applies the chi substitution within each 5-bit row, and writes the result back to the same address. It raises `done` so the round controller can hand the state memory to the add-round-constant stage.

## Interface
- No parameters; slice count (64) and line width (25) are fixed.
- `clk` input 1: rising-edge clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `chi_en` input 1: start request; sampled only in IDLE.
- `line_in` input 25: state line at address `cnt_value`; combinational memory read, valid in the same cycle.
- `cnt_value` output 6: read address (slice index).
- `write_enable` output 1: write strobe for the state memory.
- `write_addr` output 6: write address.
- `write_value` output 25: chi result to store.
- `done` output 1: one-cycle pulse when the pass completes.

## Operation
- Bit mapping within a line:
  - Bit index `5*y + x`, with column x = 0..4 and row y = 0..4.
  - Output bit: `b[5y+x] = a[5y+x] ^ (~a[5y+(x+1)%5] & a[5y+(x+2)%5])`.
  - The modulo wraps inside a row only; rows never interact.
  - The transform is purely bitwise, with no carries.
- FSM states: IDLE, RUN, FLUSH (only when CHI_OUT_REG_EN is defined), DONE.
- IDLE:
  - `cnt_value` = 0; `write_enable` = 0; `done` = 0.
  - When `chi_en` = 1, move to RUN.
- RUN:
  - Each cycle, slice `cnt_value` is read, transformed, and written; the counter then increments.
  - When `cnt_value` = 63, the counter wraps to 0.
  - From the last slice, go to FLUSH if CHI_OUT_REG_EN is defined, otherwise to DONE.
- FLUSH: the final registered write is issued; then go to DONE.
- DONE: `done` = 1 for exactly one cycle, `write_enable` = 0; then return to IDLE.
- `chi_en` is ignored outside IDLE:
  - Holding it high through DONE starts a new pass from IDLE on the next cycle.
  - A new pass never begins in the same cycle that `done` is high.
- Reset:
  - Values after reset: state IDLE, counter 0, `done` = 0, `write_enable` = 0, `write_addr` = 0, `write_value` = 0.
  - Reset asserted mid-pass aborts the pass immediately; no further writes occur, and partially updated memory is left as is.
  - Reset has priority over `chi_en` in the same cycle.
- Read-before-write on the same address is safe: each slice is read and written exactly once, in ascending address order.

## Timing
- `chi_en` sampled high at edge 0 (IDLE): RUN occupies cycles 1..64, with `cnt_value` = 0..63.
- Without CHI_OUT_REG_EN:
  - Writes are combinational from `line_in`; `write_addr` = `cnt_value`; `write_enable` is high in cycles 1..64.
  - `done` is high in cycle 65.
  - Total 65 cycles, start to done.
- With CHI_OUT_REG_EN:
  - Writes lag reads by one cycle; `write_addr` is the registered `cnt_value`.
  - `write_enable` is high in cycles 2..65; FLUSH is cycle 65.
  - `done` is high in cycle 66.
- Throughput: one slice per cycle, with no stalls.

## Configuration
- `CHI_OUT_REG_EN` defined:
  - `write_value`, `write_addr` and `write_enable` are driven from a register stage, cutting the memory-read-to-write path.
  - FLUSH is added, and latency grows by 1 cycle.
- `CHI_OUT_REG_EN` undefined:
  - Write outputs are combinational; FLUSH does not exist.
  - `write_addr` is tied to `cnt_value`.

## Test plan
- Reset values: assert `rst` for 2 cycles → all outputs 0; state IDLE.
- Known lines (one pass, memory model checked):
  - Slice 0 = 25'h0000004 → written 25'h0000005.
  - Slice 1 = 25'h0000080 → written 25'h00000A0.
  - Slice 63 = 25'h1FFFFFF → written 25'h1FFFFFF.
  - All-zero slices stay 0.
- Cycle count: `chi_en` pulsed at cycle 0 → exactly 64 write strobes, addresses 0..63 ascending, `done` high only in cycle 65 (cycle 66 with CHI_OUT_REG_EN).
- Reset mid-pass: assert `rst` during slice 20 → no writes after that cycle, `done` never pulses, and the next `chi_en` restarts from address 0.
- Back-to-back: hold `chi_en` high continuously → `done` pulses every 66 cycles (67 with CHI_OUT_REG_EN), and `done` never overlaps `write_enable`.
- Random regression: 50 random 64-line states, each pass compared against a software chi reference model → bit-exact match.
